// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide unit with HI/LO registers
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic             p_skip;

  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
  logic               b_zero, a_neg, b_neg;
  logic [WIDTH-1:0]   div_b, a_mag, b_mag, mag_q, mag_r;
  logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;

  // Full-width products: sign/zero extend to 2*WIDTH so the truncated product is exact
  always_comb begin
    a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
    b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  end

  // Quotient/remainder; signed division works on magnitudes so the
  // most-negative / -1 case wraps to most-negative with zero remainder.
  // A zero divisor is replaced by 1 only to keep the datapath defined;
  // its result is discarded at commit.
  always_comb begin
    b_zero = (B == '0);
    div_b  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    a_neg  = A[WIDTH-1];
    b_neg  = div_b[WIDTH-1];
    a_mag  = a_neg ? (~A + 1'b1) : A;
    b_mag  = b_neg ? (~div_b + 1'b1) : div_b;
    mag_q  = a_mag / b_mag;
    mag_r  = a_mag % b_mag;
    quot_s = (a_neg ^ b_neg) ? (~mag_q + 1'b1) : mag_q;
    rem_s  = a_neg ? (~mag_r + 1'b1) : mag_r;
    quot_u = A / div_b;
    rem_u  = A % div_b;
  end

  // Issue/run/commit control; HI/LO only change on mthi/mtlo or at commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      p_skip <= 1'b0;
      busy   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdOp)
              OP_MULT, OP_MULTU: begin
                p_hi   <= (mdOp == OP_MULT) ? prod_s[2*WIDTH-1:WIDTH] : prod_u[2*WIDTH-1:WIDTH];
                p_lo   <= (mdOp == OP_MULT) ? prod_s[WIDTH-1:0]       : prod_u[WIDTH-1:0];
                p_skip <= 1'b0;
                cnt    <= CW'(MULT_CYCLES);
                busy   <= 1'b1;
                state  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                p_hi   <= (mdOp == OP_DIV) ? rem_s  : rem_u;
                p_lo   <= (mdOp == OP_DIV) ? quot_s : quot_u;
                p_skip <= b_zero;
                cnt    <= CW'(DIV_CYCLES);
                busy   <= 1'b1;
                state  <= RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (!p_skip) begin
              HI <= p_hi;
              LO <= p_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq
module tb_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        busy0, busy1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int n_cmp;
  int n_fail;

  logic [31:0] mhi [2];
  logic [31:0] mlo [2];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl [12];

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u0 (
    .clk(clk), .reset(rst_n), .start(start0), .mdOp(op0), .A(a0), .B(b0),
    .busy(busy0), .HI(hi0), .LO(lo0)
  );

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(10)) u1 (
    .clk(clk), .reset(rst_n), .start(start1), .mdOp(op1), .A(a1), .B(b1),
    .busy(busy1), .HI(hi1), .LO(lo1)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy0;
  endfunction

  function automatic logic [31:0] get_hi(input int sel);
    return (sel == 1) ? hi1 : hi0;
  endfunction

  function automatic logic [31:0] get_lo(input int sel);
    return (sel == 1) ? lo1 : lo0;
  endfunction

  function automatic int exp_cycles(input int sel, input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return (sel == 1) ? 1 : 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // reference model: architectural effect of one issued operation
  function automatic void model_apply(input int sel, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin
        q = sa * sb;
        mhi[sel] = 32'(q >>> 32);
        mlo[sel] = 32'(q);
      end
      3'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        mhi[sel] = pu[63:32];
        mlo[sel] = pu[31:0];
      end
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        mlo[sel] = 32'(q);
        mhi[sel] = 32'(r);
      end
      3'd4: if (b != 0) begin
        mlo[sel] = a / b;
        mhi[sel] = a % b;
      end
      3'd5: mhi[sel] = a;
      3'd6: mlo[sel] = a;
      default: ;
    endcase
  endfunction

  // issue one op, count busy cycles, verify HI/LO hold while busy and operands are not re-sampled
  task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
    logic [31:0] old_hi, old_lo;
    old_hi = get_hi(sel);
    old_lo = get_lo(sel);
    @(negedge clk);
    if (sel == 1) begin start1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else          begin start0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    @(posedge clk);
    @(negedge clk);
    if (sel == 1) begin start1 = 1'b0; a1 = $urandom; b1 = $urandom; end
    else          begin start0 = 1'b0; a0 = $urandom; b0 = $urandom; end
    cyc = 0;
    while (get_busy(sel) && cyc < 100) begin
      check("hi_hold", get_hi(sel), old_hi);
      check("lo_hold", get_lo(sel), old_lo);
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", cyc);
    end
    hi_o = get_hi(sel);
    lo_o = get_lo(sel);
  endtask

  initial begin
    int          cyc;
    logic [31:0] h, l, ra, rb;
    logic [2:0]  rop;

    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start0 = 1'b0; op0 = 3'd0; a0 = '0; b0 = '0;
    start1 = 1'b0; op1 = 3'd0; a1 = '0; b1 = '0;
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;

    tbl[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    tbl[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
    tbl[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tbl[3]  = '{3'd4, 32'd7,         32'd2,        32'd1,         32'd3,         10};
    tbl[4]  = '{3'd3, 32'd5,         32'd0,        32'd1,         32'd3,         10};
    tbl[5]  = '{3'd5, 32'h1234,      32'd9,        32'h1234,      32'd3,         0};
    tbl[6]  = '{3'd6, 32'h5678,      32'd9,        32'h1234,      32'h5678,      0};
    tbl[7]  = '{3'd0, 32'hDEAD,      32'hBEEF,     32'h1234,      32'h5678,      0};
    tbl[8]  = '{3'd7, 32'hDEAD,      32'hBEEF,     32'h1234,      32'h5678,      0};
    tbl[9]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 10};
    tbl[10] = '{3'd4, 32'hFFFF_FFFF, 32'd0,        32'h0,         32'h8000_0000, 10};
    tbl[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        5};

    repeat (3) @(negedge clk);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    check("rst_hi0", hi0, 32'd0);
    check("rst_lo0", lo0, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // spec vectors, applied back to back
    for (int i = 0; i < 12; i++) begin
      run_op(0, tbl[i].op, tbl[i].a, tbl[i].b, cyc, h, l);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("vec%0d_hi", i), h, tbl[i].hi);
      check($sformatf("vec%0d_lo", i), l, tbl[i].lo);
      mhi[0] = tbl[i].hi;
      mlo[0] = tbl[i].lo;
    end

    // start while busy is ignored
    @(negedge clk);
    start0 = 1'b1; op0 = 3'd1; a0 = 32'd5; b0 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    check("ign_busy_first", {31'd0, busy0}, 32'd1);
    start0 = 1'b1; op0 = 3'd1; a0 = 32'd100; b0 = 32'd100;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 1;
    while (busy0 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("ign_cycles", 32'(cyc), 32'd5);
    check("ign_hi", hi0, 32'd0);
    check("ign_lo", lo0, 32'd35);
    cyc = 0;
    repeat (8) begin
      if (busy0) cyc++;
      @(negedge clk);
    end
    check("ign_no_extra_busy", 32'(cyc), 32'd0);
    mhi[0] = 32'd0;
    mlo[0] = 32'd35;

    // MULT_CYCLES=1 instance
    run_op(1, 3'd1, 32'hFFFF_FFFE, 32'd3, cyc, h, l);
    check("m1_cycles", 32'(cyc), 32'd1);
    check("m1_hi", h, 32'hFFFF_FFFF);
    check("m1_lo", l, 32'hFFFF_FFFA);
    mhi[1] = h; mlo[1] = l;
    run_op(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, h, l);
    check("m1u_cycles", 32'(cyc), 32'd1);
    check("m1u_hi", h, 32'hFFFF_FFFE);
    check("m1u_lo", l, 32'h0000_0001);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = ($urandom_range(0, 1) == 1) ? 32'(-$urandom_range(1, 9)) : 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op(0, rop, ra, rb, cyc, h, l);
      model_apply(0, rop, ra, rb);
      check($sformatf("rnd%0d_op%0d_cycles", i, rop), 32'(cyc), 32'(exp_cycles(0, rop)));
      check($sformatf("rnd%0d_op%0d_hi", i, rop), h, mhi[0]);
      check($sformatf("rnd%0d_op%0d_lo", i, rop), l, mlo[0]);
    end

    // asynchronous reset during cycle 3 of a div aborts it
    @(negedge clk);
    start0 = 1'b1; op0 = 3'd3; a0 = 32'd100; b0 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy0}, 32'd0);
    check("arst_hi", hi0, 32'd0);
    check("arst_lo", lo0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy0) cyc++;
    end
    check("arst_no_busy", 32'(cyc), 32'd0);
    check("arst_no_commit_hi", hi0, 32'd0);
    check("arst_no_commit_lo", lo0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Executes mult, multu, div, divu over a configurable number of cycles.
- Also executes single-cycle mthi/mtlo writes.
- Exposes a registered busy flag that the hazard processor uses to stall mfhi/mflo/md instructions in D.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy duration of mult/multu in cycles; minimum 1.
- DIV_CYCLES, 10, busy duration of div/divu in cycles; minimum 1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe, high for one cycle with a valid mdOp of the mult/div family.
- mdOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
- A  input  WIDTH  forwarded rs operand (Ers_f).
- B  input  WIDTH  forwarded rt operand (Ert_f).
- busy  output  1  high while a multi-cycle operation is in progress.
- HI  output  WIDTH  committed HI register.
- LO  output  WIDTH  committed LO register.

Behaviour:
- Reset (reset low, asynchronous): HI=0, LO=0, busy=0, cycle counter=0, pending result registers=0, FSM=IDLE.
- Reset asserted mid-operation aborts it; no commit occurs after reset releases.
- FSM states:
  - IDLE: entered from reset or after a commit.
  - RUN: entered from IDLE at a posedge with start=1 and mdOp in {1,2,3,4}.
- IDLE to RUN transition:
  - Latches the full result into pending registers (pHI, pLO).
  - Loads the counter with MULT_CYCLES or DIV_CYCLES.
  - busy goes high for the next cycle.
- RUN:
  - Counter decrements each cycle.
  - At the posedge where the counter equals 1: HI<=pHI, LO<=pLO, busy<=0, FSM returns to IDLE.
  - busy is therefore high for exactly N cycles after the issue edge (N = MULT_CYCLES or DIV_CYCLES).
  - The new HI/LO values are visible in the first cycle with busy=0.
- HI/LO hold their old committed values throughout RUN.
- mthi/mtlo (mdOp 5/6 with start=1, in IDLE): HI<=A or LO<=A at that edge; busy stays 0; one-cycle latency.
- start while busy=1 is ignored: no state change, and the in-flight op is unaffected. The hazard processor must stall rather than rely on this.
- start=1 with mdOp 0 or 7: no effect.
- mdOp is ignored when start=0.
- Arithmetic:
  - mult: signed WIDTH x WIDTH to 2*WIDTH product; HI=upper WIDTH bits, LO=lower WIDTH bits.
  - multu: same as mult, unsigned.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (A).
  - divu: unsigned quotient/remainder.
  - div with A=most-negative, B=-1: LO=most-negative, HI=0, no trap.
  - Divide by zero (B=0, div or divu): the op still runs the full DIV_CYCLES with busy high, but HI and LO are left unchanged at commit.
- Operands are sampled only at the issue edge. Changes on A/B during RUN have no effect.
- Back-to-back operation: a start in the first cycle after busy falls is accepted normally.
- Both pipeline stall and mfhi/mflo reads are external. This block only provides busy and HI/LO.

Test Plan:
- Reset and mult:
  - Stimulus: reset low, then high; start mult, A=32'hFFFF_FFFE (-2), B=3.
  - Required: busy=1 for exactly 5 cycles; HI stays 0 during busy; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- multu:
  - Stimulus: A=32'hFFFF_FFFF, B=2.
  - Required: after 5 busy cycles, HI=1, LO=32'hFFFF_FFFE.
- div signed:
  - Stimulus: A=-7, B=2.
  - Required: busy high 10 cycles; then LO=-3 (32'hFFFF_FFFD), HI=-1 (32'hFFFF_FFFF).
- divu, then divide by zero:
  - Stimulus: divu A=7, B=2; then div with B=0.
  - Required: after divu, LO=3, HI=1; the divide by zero gives 10 busy cycles and HI/LO still 1/3.
- Single-cycle writes and ignored start:
  - Stimulus: mthi A=32'h1234 while idle; then start mult while busy.
  - Required: HI=32'h1234 one edge later with busy=0; the second start is ignored, the first result commits, and there is no extra busy period.
- Reset mid-operation:
  - Stimulus: assert reset during cycle 3 of a div.
  - Required: busy=0 and HI=LO=0 immediately (asynchronous); no commit after release.
- Min-negative division:
  - Stimulus: div A=32'h8000_0000, B=32'hFFFF_FFFF.
  - Required: LO=32'h8000_0000, HI=0.
- Parameters:
  - Stimulus: rerun the mult test with MULT_CYCLES=1.
  - Required: busy is high for 1 cycle.
